// File: rtl/ddr_if_pkg.sv
// ddr_if_pkg: MIG app-interface command codes, responder FSM states and default widths.
package ddr_if_pkg;
    localparam int DEF_ADDR_W = 27;
    localparam int DEF_DATA_W = 128;
    localparam int DEF_OFFSET_LEN = 4;
    localparam logic [2:0] APP_CMD_WRITE = 3'b000;
    localparam logic [2:0] APP_CMD_READ = 3'b001;
    typedef enum logic [2:0] {IDLE, RD_CMD, RD_WAIT, WR_CMD, WR_DONE} state_t;
endpackage

// File: rtl/ddr_line_responder.sv
// ddr_line_responder: services cache line read/write requests one at a time on a MIG-style app interface.
module ddr_line_responder
    import ddr_if_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int OFFSET_LEN = DEF_OFFSET_LEN,
    parameter int MASK_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] req_rd_addr,
    input  logic              req_rd_en,
    output logic              rsp_rd_fin,
    output logic [DATA_W-1:0] rsp_rd_data,
    input  logic [ADDR_W-1:0] req_wr_addr,
    input  logic [DATA_W-1:0] req_wr_data,
    input  logic              req_wr_en,
    output logic              rsp_wr_fin,
    input  logic              init_calib_complete,
    output logic [ADDR_W-1:0] app_addr,
    output logic [2:0]        app_cmd,
    output logic              app_en,
    input  logic              app_rdy,
    output logic [DATA_W-1:0] app_wdf_data,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    output logic [MASK_W-1:0] app_wdf_mask,
    input  logic              app_wdf_rdy,
    input  logic [DATA_W-1:0] app_rd_data,
    input  logic              app_rd_data_valid,
    output logic              proto_err
);
    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFFSET_LEN){1'b1}}, {OFFSET_LEN{1'b0}}};
    state_t state, next;
    logic rd_valid, wr_valid, cmd_ok, dat_ok;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic cmd_acc, dat_acc, rd_issue, wr_exit;

    assign app_en = state == RD_CMD || (state == WR_CMD && !cmd_ok);
    assign app_cmd = state == RD_CMD ? APP_CMD_READ : APP_CMD_WRITE;
    assign app_addr = state == RD_CMD ? rd_addr : state == WR_CMD ? wr_addr : '0;
    assign app_wdf_wren = state == WR_CMD && !dat_ok;
    assign app_wdf_end = app_wdf_wren;
    assign app_wdf_data = app_wdf_wren ? wr_data : '0;
    assign app_wdf_mask = '0;
    assign rsp_wr_fin = state == WR_DONE;
    assign cmd_acc = app_en && app_rdy;
    assign dat_acc = app_wdf_wren && app_wdf_rdy;
    assign rd_issue = state == RD_CMD && app_rdy;
    // command and data may be accepted in either order; leave once both are done
    assign wr_exit = state == WR_CMD && (cmd_ok || cmd_acc) && (dat_ok || dat_acc);

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = !init_calib_complete ? IDLE :
                            (rd_valid || req_rd_en) ? RD_CMD :
                            (wr_valid || req_wr_en) ? WR_CMD : IDLE;
            RD_CMD:  next = app_rdy ? RD_WAIT : RD_CMD;
            RD_WAIT: next = app_rd_data_valid ? IDLE : RD_WAIT;
            WR_CMD:  next = wr_exit ? WR_DONE : WR_CMD;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
            rd_valid <= 1'b0;
            wr_valid <= 1'b0;
            rd_addr <= '0;
            wr_addr <= '0;
            wr_data <= '0;
            cmd_ok <= 1'b0;
            dat_ok <= 1'b0;
            proto_err <= 1'b0;
            rsp_rd_fin <= 1'b0;
            rsp_rd_data <= '0;
        end else begin
            state <= next;
            if (rd_issue)
                rd_valid <= 1'b0;
            if (wr_exit)
                wr_valid <= 1'b0;
            if (req_rd_en && !rd_valid) begin
                rd_valid <= 1'b1;
                rd_addr <= req_rd_addr & LINE_MASK;
            end
            if (req_wr_en && !wr_valid) begin
                wr_valid <= 1'b1;
                wr_addr <= req_wr_addr & LINE_MASK;
                wr_data <= req_wr_data;
            end
            if ((req_rd_en && rd_valid) || (req_wr_en && wr_valid))
                proto_err <= 1'b1;
            cmd_ok <= state == WR_CMD && !wr_exit && (cmd_ok || cmd_acc);
            dat_ok <= state == WR_CMD && !wr_exit && (dat_ok || dat_acc);
            rsp_rd_fin <= state == RD_WAIT && app_rd_data_valid;
            rsp_rd_data <= (state == RD_WAIT && app_rd_data_valid) ? app_rd_data : '0;
        end
    end
endmodule
